// File: rtl/printer_pkg.sv
// Shared printer definitions: head mode codes and bus widths used by the
// carriage head and the job sequencer.
package printer_pkg;
  localparam int PRINTER_MODE_W = 8;
  localparam int PRINTER_PASS_W = 8;
  localparam int WD_W           = 16;

  typedef logic [PRINTER_MODE_W-1:0] printer_mode_t;
  typedef logic [PRINTER_PASS_W-1:0] printer_pass_t;

  localparam printer_mode_t S_PRINTER_STOP    = 8'd0;
  localparam printer_mode_t S_PRINTER_CONTROL = 8'd1;
  localparam printer_mode_t S_PRINTER_CENTER  = 8'd2;
  localparam printer_mode_t S_PRINTER_COLLECT = 8'd3;
endpackage

// File: rtl/phase_watchdog.sv
// Free-running phase cycle counter; expired_o flags the last cycle of a
// limit_i-cycle window so the owner can transition on that edge.
module phase_watchdog
  import printer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [WD_W-1:0] limit_i,
  output logic            expired_o
);

  localparam logic [WD_W-1:0] CNT_ONE = 'd1;

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Widened compare so a limit near the counter's top never wraps.
  assign expired_o = en_i && (({1'b0, cnt_q} + 17'd1) == {1'b0, limit_i});

endmodule

// File: rtl/printer_job_sequencer.sv
// Job-level carriage controller: settle, center, N sweeps, collect, park,
// with per-phase watchdogs that drop into a sticky FAULT state.
module printer_job_sequencer
  import printer_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int CENTER_TIMEOUT  = 4000,
  parameter int PASS_TIMEOUT    = 20000,
  parameter int COLLECT_TIMEOUT = 4000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic [PRINTER_PASS_W-1:0] Passes,
  input  logic                      HeadDone,
  input  logic                      HeadLineReset,
  output logic [PRINTER_MODE_W-1:0] Mode,
  output logic                      Busy,
  output logic                      JobDone,
  output logic                      Fault,
  output logic [PRINTER_PASS_W-1:0] PassCount
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_CENTER, ST_CONTROL, ST_COLLECT, ST_PARK, ST_FAULT
  } seq_state_e;

  localparam logic [WD_W-1:0] SETTLE_LIM  = WD_W'(SETTLE_CYCLES);
  localparam logic [WD_W-1:0] CENTER_LIM  = WD_W'(CENTER_TIMEOUT);
  localparam logic [WD_W-1:0] PASS_LIM    = WD_W'(PASS_TIMEOUT);
  localparam logic [WD_W-1:0] COLLECT_LIM = WD_W'(COLLECT_TIMEOUT);

  function automatic printer_mode_t mode_of(seq_state_e s);
    case (s)
      ST_CENTER:  return S_PRINTER_CENTER;
      ST_CONTROL: return S_PRINTER_CONTROL;
      ST_COLLECT: return S_PRINTER_COLLECT;
      default:    return S_PRINTER_STOP;
    endcase
  endfunction

  function automatic logic is_busy(seq_state_e s);
    return !(s == ST_IDLE || s == ST_FAULT);
  endfunction

  seq_state_e    state_q, state_d, next_q, next_d;
  printer_pass_t passes_q, passes_d, pcnt_q, pcnt_d;
  printer_mode_t mode_q;
  logic          hlr_prev_q, aborted_q, aborted_d;
  logic          busy_q, jdone_q, jdone_d, fault_q, fault_d;

  logic            rise;
  printer_pass_t   pcnt_inc;
  logic            wd_en, wd_clr, wd_exp;
  logic [WD_W-1:0] wd_limit;
  logic            st_en, st_clr, st_exp;

  assign rise     = HeadLineReset & ~hlr_prev_q;
  assign pcnt_inc = pcnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    passes_d  = passes_q;
    pcnt_d    = pcnt_q;
    aborted_d = aborted_q;
    fault_d   = fault_q;
    jdone_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (Start && !Abort) begin
          passes_d  = Passes;
          pcnt_d    = '0;
          fault_d   = 1'b0;
          aborted_d = 1'b0;
          next_d    = ST_CENTER;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (Abort) begin
          state_d   = ST_PARK;
          aborted_d = 1'b1;
        end else if (st_exp) begin
          state_d = next_q;
        end
      end
      ST_CENTER: begin
        if (Abort) begin
          state_d   = ST_PARK;
          aborted_d = 1'b1;
        end else if (HeadDone) begin
          // Zero-pass jobs skip sweeping; the head clears Done itself in CONTROL.
          if (passes_q == '0) begin
            state_d = ST_SETTLE;
            next_d  = ST_COLLECT;
          end else begin
            state_d = ST_CONTROL;
          end
        end else if (wd_exp) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_CONTROL: begin
        if (Abort) begin
          state_d   = ST_PARK;
          aborted_d = 1'b1;
        end else if (rise) begin
          pcnt_d = pcnt_inc;
          if (pcnt_inc == passes_q) begin
            state_d = ST_SETTLE;
            next_d  = ST_COLLECT;
          end
        end else if (wd_exp) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (Abort) begin
          state_d   = ST_PARK;
          aborted_d = 1'b1;
        end else if (HeadDone) begin
          state_d = ST_PARK;
        end else if (wd_exp) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_PARK: begin
        if (st_exp) begin
          state_d = ST_IDLE;
          jdone_d = !aborted_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wd_limit = '1;
    case (state_q)
      ST_CENTER:  wd_limit = CENTER_LIM;
      ST_CONTROL: wd_limit = PASS_LIM;
      ST_COLLECT: wd_limit = COLLECT_LIM;
      default:    wd_limit = '1;
    endcase
  end

  // A reversal restarts the pass watchdog without a state change.
  assign wd_en  = (state_q == ST_CENTER) || (state_q == ST_CONTROL) ||
                  (state_q == ST_COLLECT);
  assign wd_clr = (state_d != state_q) || ((state_q == ST_CONTROL) && rise);
  assign st_en  = (state_q == ST_SETTLE) || (state_q == ST_PARK);
  assign st_clr = (state_d != state_q);

  phase_watchdog u_wd (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .limit_i   (wd_limit),
    .expired_o (wd_exp)
  );

  phase_watchdog u_settle (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (st_clr),
    .en_i      (st_en),
    .limit_i   (SETTLE_LIM),
    .expired_o (st_exp)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      next_q     <= ST_IDLE;
      passes_q   <= '0;
      pcnt_q     <= '0;
      hlr_prev_q <= 1'b0;
      aborted_q  <= 1'b0;
      mode_q     <= S_PRINTER_STOP;
      busy_q     <= 1'b0;
      jdone_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      passes_q   <= passes_d;
      pcnt_q     <= pcnt_d;
      hlr_prev_q <= HeadLineReset;
      aborted_q  <= aborted_d;
      mode_q     <= mode_of(state_d);
      busy_q     <= is_busy(state_d);
      jdone_q    <= jdone_d;
      fault_q    <= fault_d;
    end
  end

  assign Mode      = mode_q;
  assign Busy      = busy_q;
  assign JobDone   = jdone_q;
  assign Fault     = fault_q;
  assign PassCount = pcnt_q;

endmodule

// File: tb/tb_printer_job_sequencer.sv
// Scoreboard bench: stimulus queues the expected output change (with the
// cycle gap since the previous change); a monitor pops on every change.
module tb_printer_job_sequencer;
  import printer_pkg::*;

  logic       CLK = 1'b0, RST = 1'b1, Start = 1'b0, Abort = 1'b0;
  logic       HeadDone = 1'b0, HeadLineReset = 1'b0;
  logic [7:0] Passes = 8'd0;
  logic [7:0] Mode, PassCount;
  logic       Busy, JobDone, Fault;

  printer_job_sequencer #(
    .SETTLE_CYCLES(16), .CENTER_TIMEOUT(4000),
    .PASS_TIMEOUT(20000), .COLLECT_TIMEOUT(4000)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Passes(Passes),
    .HeadDone(HeadDone), .HeadLineReset(HeadLineReset), .Mode(Mode),
    .Busy(Busy), .JobDone(JobDone), .Fault(Fault), .PassCount(PassCount)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    string       name;
    int          dt;
    logic [18:0] v;
  } exp_t;
  exp_t sb[$];

  task automatic expect_ev(string nm, int dt, logic [7:0] m, logic b,
                           logic jd, logic f, logic [7:0] pc);
    exp_t e;
    e.name = nm; e.dt = dt; e.v = {m, b, jd, f, pc};
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_job(logic [7:0] p);
    Passes = p; Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  // which: 0=HeadDone 1=HeadLineReset 2=Abort; DUT samples it n edges from now.
  task automatic pulse(int which, int n);
    tick(n - 1);
    case (which)
      0: HeadDone = 1'b1;
      1: HeadLineReset = 1'b1;
      default: Abort = 1'b1;
    endcase
    tick(1);
    HeadDone = 1'b0; HeadLineReset = 1'b0; Abort = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [18:0] cur, last;
    int          last_cyc;
    bit          first;
    exp_t        e;
    first = 1'b1; last = '0; last_cyc = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cur = {Mode, Busy, JobDone, Fault, PassCount};
        if (first || cur != last) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d got mode=%0d busy=%0d jd=%0d fault=%0d pc=%0d",
                     cyc, cur[18:11], cur[10], cur[9], cur[8], cur[7:0]);
          end else begin
            e = sb.pop_front();
            if (cur !== e.v) begin
              n_fail++;
              $display("FAIL %s got mode=%0d busy=%0d jd=%0d fault=%0d pc=%0d want mode=%0d busy=%0d jd=%0d fault=%0d pc=%0d",
                       e.name, cur[18:11], cur[10], cur[9], cur[8], cur[7:0],
                       e.v[18:11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end
            if (!first && e.dt >= 0) begin
              n_tests++;
              if (cyc - last_cyc != e.dt) begin
                n_fail++;
                $display("FAIL %s_latency got %0d cycles want %0d", e.name, cyc - last_cyc, e.dt);
              end
            end
          end
          last = cur; last_cyc = cyc; first = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    expect_ev("reset", -1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    RST = 1'b0;
    tick(3);

    // Normal job, 3 passes
    expect_ev("n_settle", -1, 0, 1, 0, 0, 0);     start_job(3);
    expect_ev("n_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("n_control", 50, 1, 1, 0, 0, 0);    pulse(0, 50);
    expect_ev("n_rev1", 1000, 1, 1, 0, 0, 1);     pulse(1, 1000);
    expect_ev("n_rev2", 1000, 1, 1, 0, 0, 2);     pulse(1, 1000);
    expect_ev("n_rev3", 1000, 0, 1, 0, 0, 3);     pulse(1, 1000);
    expect_ev("n_collect", 16, 3, 1, 0, 0, 3);    tick(16);
    expect_ev("n_park", 20, 0, 1, 0, 0, 3);       pulse(0, 20);
    expect_ev("n_jobdone", 16, 0, 0, 1, 0, 3);
    expect_ev("n_jobdone_end", 1, 0, 0, 0, 0, 3); tick(17);
    tick(5);

    // Zero passes
    expect_ev("z_settle", -1, 0, 1, 0, 0, 0);     start_job(0);
    expect_ev("z_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("z_settle2", 50, 0, 1, 0, 0, 0);    pulse(0, 50);
    expect_ev("z_collect", 16, 3, 1, 0, 0, 0);    tick(16);
    expect_ev("z_park", 20, 0, 1, 0, 0, 0);       pulse(0, 20);
    expect_ev("z_jobdone", 16, 0, 0, 1, 0, 0);
    expect_ev("z_jobdone_end", 1, 0, 0, 0, 0, 0); tick(17);
    tick(5);

    // Center stall
    expect_ev("c_settle", -1, 0, 1, 0, 0, 0);     start_job(1);
    expect_ev("c_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("c_fault", 4000, 0, 0, 0, 1, 0);    tick(4000);
    tick(5);

    // Pass stall: 2 of 5 reversals
    expect_ev("p_settle", -1, 0, 1, 0, 0, 0);     start_job(5);
    expect_ev("p_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("p_control", 50, 1, 1, 0, 0, 0);    pulse(0, 50);
    expect_ev("p_rev1", 1000, 1, 1, 0, 0, 1);     pulse(1, 1000);
    expect_ev("p_rev2", 1000, 1, 1, 0, 0, 2);     pulse(1, 1000);
    expect_ev("p_fault", 20000, 0, 0, 0, 1, 2);   tick(20000);
    tick(5);

    // Restart from FAULT, Start while busy, abort mid-CONTROL
    expect_ev("a_settle", -1, 0, 1, 0, 0, 0);     start_job(1);
    expect_ev("a_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("a_control", 10, 1, 1, 0, 0, 0);    pulse(0, 10);
    tick(40);
    Passes = 8'd0; Start = 1'b1; tick(1); Start = 1'b0;
    expect_ev("a_park", 100, 0, 1, 0, 0, 0);      pulse(2, 59);
    expect_ev("a_idle_nodone", 16, 0, 0, 0, 0, 0); tick(16);
    tick(3);
    Start = 1'b1; Abort = 1'b1; tick(1); Start = 1'b0; Abort = 1'b0;
    tick(20);

    // RST in COLLECT with HeadLineReset held high across release
    expect_ev("r_settle", -1, 0, 1, 0, 0, 0);     start_job(0);
    expect_ev("r_center", 16, 2, 1, 0, 0, 0);     tick(16);
    expect_ev("r_settle2", 5, 0, 1, 0, 0, 0);     pulse(0, 5);
    expect_ev("r_collect", 16, 3, 1, 0, 0, 0);    tick(16);
    expect_ev("r_reset", 1, 0, 0, 0, 0, 0);
    RST = 1'b1; HeadLineReset = 1'b1; tick(1);
    RST = 1'b0; tick(5);
    HeadLineReset = 1'b0; tick(3);
    expect_ev("r2_settle", -1, 0, 1, 0, 0, 0);    start_job(2);
    expect_ev("r2_center", 16, 2, 1, 0, 0, 0);    tick(16);
    expect_ev("r2_park", 3, 0, 1, 0, 0, 0);       pulse(2, 3);
    expect_ev("r2_idle", 16, 0, 0, 0, 0, 0);      tick(16);
    tick(10);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got %0d still pending want 0 (next %s)", sb.size(), sb[0].name);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
